axil_reg_bank: RTL and testbench

- Parametrised AXI4-Lite slave register bank: NUM_REGS software-visible registers of DATA_WIDTH bits, with independent AW/W acceptance, byte strobes and decode-error responses.
- Sits behind the DMA control-port interconnect and drives the register contents and per-register write pulses to DMA engine logic.

---
 rtl/axil_reg_bank.sv | 164 ++++++++++++++++
 tb/tb_axil_reg_bank.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave register bank: NUM_REGS x DATA_WIDTH registers, byte strobes, DECERR decode.
// Define AXIL_REG_BANK_ALIGN_CHECK_EN to answer misaligned in-range accesses with SLVERR.
module axil_reg_bank #(
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           WVALID,
    output logic                           WREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    output logic                           BVALID,
    input  logic                           BREADY,
    output logic [1:0]                     BRESP,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(BYTES);
    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(NUM_REGS * BYTES);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, HAVE_AW, HAVE_W, RESP} wstate_t;

    function automatic logic [1:0] decode_resp(input logic [ADDR_WIDTH-1:0] a);
        if ({1'b0, a} >= SPAN) return RESP_DECERR;
`ifdef AXIL_REG_BANK_ALIGN_CHECK_EN
        if (a[ADDR_LSB-1:0] != '0) return RESP_SLVERR;
`endif
        return RESP_OKAY;
    endfunction

    logic                                 live;
    wstate_t                              wstate, wstate_nxt;
    logic                                 aw_fire, w_fire, wr_commit, wr_en;
    logic [ADDR_WIDTH-1:0]                aw_addr_q, wr_addr;
    logic [DATA_WIDTH-1:0]                w_data_q, wr_data;
    logic [BYTES-1:0]                     w_strb_q, wr_strb;
    logic [1:0]                           wr_resp, rd_resp;
    logic [IDX_W-1:0]                     wr_idx, rd_idx;
    logic [NUM_REGS-1:0]                  wr_hit;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs;

    assign reg_q  = regs;
    assign BVALID = (wstate == RESP);

    // Write channel handshakes and next state
    always_comb begin
        wstate_nxt = wstate;
        wr_commit  = 1'b0;
        AWREADY    = live && (wstate == IDLE || wstate == HAVE_W);
        WREADY     = live && (wstate == IDLE || wstate == HAVE_AW);
        aw_fire    = AWVALID && AWREADY;
        w_fire     = WVALID && WREADY;
        case (wstate)
            IDLE: begin
                if (aw_fire && w_fire) begin
                    wstate_nxt = RESP;
                    wr_commit  = 1'b1;
                end else if (aw_fire) begin
                    wstate_nxt = HAVE_AW;
                end else if (w_fire) begin
                    wstate_nxt = HAVE_W;
                end
            end
            HAVE_AW: if (w_fire) begin
                wstate_nxt = RESP;
                wr_commit  = 1'b1;
            end
            HAVE_W: if (aw_fire) begin
                wstate_nxt = RESP;
                wr_commit  = 1'b1;
            end
            RESP:    if (BREADY) wstate_nxt = IDLE;
            default: wstate_nxt = IDLE;
        endcase
    end

    // Commit uses whichever half arrives on the committing edge, the other from capture
    always_comb begin
        wr_addr = (wstate == HAVE_AW) ? aw_addr_q : AWADDR;
        wr_data = (wstate == HAVE_W)  ? w_data_q  : WDATA;
        wr_strb = (wstate == HAVE_W)  ? w_strb_q  : WSTRB;
        wr_resp = decode_resp(wr_addr);
        wr_idx  = wr_addr[ADDR_LSB +: IDX_W];
        wr_en   = wr_commit && (wr_resp == RESP_OKAY) && (|wr_strb);
        wr_hit  = '0;
        for (int i = 0; i < NUM_REGS; i++)
            wr_hit[i] = wr_en && (wr_idx == IDX_W'(i));
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            live         <= 1'b0;
            wstate       <= IDLE;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            BRESP        <= RESP_OKAY;
            reg_wr_pulse <= '0;
        end else begin
            live         <= 1'b1;
            wstate       <= wstate_nxt;
            reg_wr_pulse <= wr_hit;
            if (aw_fire) aw_addr_q <= AWADDR;
            if (w_fire) begin
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end
            if (wr_commit) BRESP <= wr_resp;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (wr_hit[i])
                    for (int b = 0; b < BYTES; b++)
                        if (wr_strb[b]) regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
    end

    // Read path; RDATA samples pre-edge register state, so a same-edge write returns old data
    always_comb begin
        ARREADY = live && !RVALID;
        rd_resp = decode_resp(ARADDR);
        rd_idx  = ARADDR[ADDR_LSB +: IDX_W];
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            RVALID <= 1'b0;
            RDATA  <= '0;
            RRESP  <= RESP_OKAY;
        end else if (ARVALID && ARREADY) begin
            RVALID <= 1'b1;
            RRESP  <= rd_resp;
            RDATA  <= (rd_resp == RESP_OKAY) ? regs[rd_idx] : '0;
        end else if (RREADY) begin
            RVALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed self-checking bench for axil_reg_bank (default 12/32/16 configuration).
module tb_axil_reg_bank;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NR = 16;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic              AWVALID = 1'b0, AWREADY;
    logic [AW-1:0]     AWADDR = '0;
    logic              WVALID = 1'b0, WREADY;
    logic [DW-1:0]     WDATA = '0;
    logic [DW/8-1:0]   WSTRB = '0;
    logic              BVALID;
    logic              BREADY = 1'b0;
    logic [1:0]        BRESP;
    logic              ARVALID = 1'b0, ARREADY;
    logic [AW-1:0]     ARADDR = '0;
    logic              RVALID;
    logic              RREADY = 1'b0;
    logic [DW-1:0]     RDATA;
    logic [1:0]        RRESP;
    logic [NR*DW-1:0]  reg_q;
    logic [NR-1:0]     reg_wr_pulse;

    int errors = 0;
    int checks = 0;

    always #5 ACLK = ~ACLK;

    axil_reg_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RESET_VALUE('0)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rq(input int i);
        return reg_q[i*DW +: DW];
    endfunction

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic [NR-1:0] pulse);
        logic aw_hs, w_hs;
        @(negedge ACLK);
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
        for (int k = 0; k < 20 && (AWVALID || WVALID); k++) begin
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            @(negedge ACLK);
            if (aw_hs) AWVALID = 1'b0;
            if (w_hs)  WVALID  = 1'b0;
        end
        chk("wr_handshake", 64'({AWVALID, WVALID}), 64'd0);
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("wr_bvalid", 64'(BVALID), 64'd1);
        resp  = BRESP;
        pulse = reg_wr_pulse;
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        chk("wr_pulse_clear", 64'(reg_wr_pulse), 64'd0);
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] resp);
        logic hs;
        @(negedge ACLK);
        ARADDR = a; ARVALID = 1'b1;
        for (int k = 0; k < 20 && ARVALID; k++) begin
            hs = ARREADY;
            @(negedge ACLK);
            if (hs) ARVALID = 1'b0;
        end
        chk("rd_handshake", 64'(ARVALID), 64'd0);
        ARVALID = 1'b0;
        chk("rd_rvalid", 64'(RVALID), 64'd1);
        d    = RDATA;
        resp = RRESP;
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [1:0]       resp;
        logic [NR-1:0]    pulse;
        logic [DW-1:0]    rd;
        logic [NR*DW-1:0] snap;

        // Reset state
        repeat (2) @(negedge ACLK);
        chk("rst_readies", 64'({AWREADY, WREADY, ARREADY}), 64'd0);
        chk("rst_valids", 64'({BVALID, RVALID}), 64'd0);
        chk("rst_resps", 64'({BRESP, RRESP}), 64'd0);
        chk("rst_rdata", 64'(RDATA), 64'd0);
        chk("rst_reg_q", 64'(reg_q == '0), 64'd1);
        chk("rst_pulse", 64'(reg_wr_pulse), 64'd0);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("post_rst_readies", 64'({AWREADY, WREADY, ARREADY}), 64'h7);

        // AW and W together
        axi_write(12'h008, 32'hDEADBEEF, 4'hF, resp, pulse);
        chk("t1_bresp", 64'(resp), 64'd0);
        chk("t1_pulse", 64'(pulse), 64'h0004);
        chk("t1_reg2", 64'(rq(2)), 64'hDEADBEEF);
        axi_read(12'h008, rd, resp);
        chk("t1_rdata", 64'(rd), 64'hDEADBEEF);
        chk("t1_rresp", 64'(resp), 64'd0);

        // W three cycles ahead of AW, partial strobes
        @(negedge ACLK);
        WDATA = 32'h11223344; WSTRB = 4'b0101; WVALID = 1'b1;
        @(negedge ACLK);
        WVALID = 1'b0;
        chk("t2_have_w_bvalid", 64'(BVALID), 64'd0);
        chk("t2_have_w_ready", 64'({AWREADY, WREADY}), 64'b10);
        repeat (2) begin
            @(negedge ACLK);
            chk("t2_wait_bvalid", 64'(BVALID), 64'd0);
        end
        AWADDR = 12'h004; AWVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0;
        chk("t2_bvalid", 64'(BVALID), 64'd1);
        chk("t2_bresp", 64'(BRESP), 64'd0);
        chk("t2_pulse", 64'(reg_wr_pulse), 64'h0002);
        chk("t2_reg1", 64'(rq(1)), 64'h00220044);
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;

        // Out-of-range write and read
        snap = reg_q;
        axi_write(12'h040, 32'h12345678, 4'hF, resp, pulse);
        chk("t3_bresp", 64'(resp), 64'd3);
        chk("t3_pulse", 64'(pulse), 64'd0);
        chk("t3_reg_q_same", 64'(reg_q == snap), 64'd1);
        axi_read(12'h100, rd, resp);
        chk("t3_rresp", 64'(resp), 64'd3);
        chk("t3_rdata", 64'(rd), 64'd0);

        // Backpressure on B
        @(negedge ACLK);
        AWADDR = 12'h00C; WDATA = 32'hCAFEF00D; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("t4_b_hold_valid", 64'(BVALID), 64'd1);
            chk("t4_b_hold_resp", 64'(BRESP), 64'd0);
            chk("t4_b_hold_ready", 64'({AWREADY, WREADY}), 64'd0);
            @(negedge ACLK);
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        chk("t4_reg3", 64'(rq(3)), 64'hCAFEF00D);

        // Backpressure on R
        @(negedge ACLK);
        ARADDR = 12'h008; ARVALID = 1'b1;
        @(negedge ACLK);
        ARVALID = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("t4_r_hold_valid", 64'(RVALID), 64'd1);
            chk("t4_r_hold_data", 64'(RDATA), 64'hDEADBEEF);
            chk("t4_r_hold_ready", 64'(ARREADY), 64'd0);
            @(negedge ACLK);
        end
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;

        // Read and write to the same register on the same edge
        @(negedge ACLK);
        AWADDR = 12'h000; WDATA = 32'h5; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 12'h000; ARVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        chk("t5_rvalid", 64'(RVALID), 64'd1);
        chk("t5_old_rdata", 64'(RDATA), 64'd0);
        chk("t5_reg0", 64'(rq(0)), 64'h5);
        BREADY = 1'b1; RREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0; RREADY = 1'b0;
        axi_read(12'h000, rd, resp);
        chk("t5_new_rdata", 64'(rd), 64'h5);

        // Zero strobes
        axi_write(12'h008, 32'hFFFFFFFF, 4'h0, resp, pulse);
        chk("t6_bresp", 64'(resp), 64'd0);
        chk("t6_pulse", 64'(pulse), 64'd0);
        chk("t6_reg2", 64'(rq(2)), 64'hDEADBEEF);

        // Reset with AW captured
        @(negedge ACLK);
        AWADDR = 12'h010; AWVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0;
        chk("t7_have_aw_bvalid", 64'(BVALID), 64'd0);
        #2 ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        chk("t7_reg_q_reset", 64'(reg_q == '0), 64'd1);
        @(negedge ACLK);
        WDATA = 32'h77777777; WSTRB = 4'hF; WVALID = 1'b1;
        @(negedge ACLK);
        WVALID = 1'b0;
        repeat (3) begin
            chk("t7_no_bvalid", 64'(BVALID), 64'd0);
            @(negedge ACLK);
        end
        chk("t7_reg4", 64'(rq(4)), 64'd0);
        AWADDR = 12'h080; AWVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0;
        chk("t7_flush_bvalid", 64'(BVALID), 64'd1);
        chk("t7_flush_bresp", 64'(BRESP), 64'd3);
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;

        // Misaligned address
        axi_write(12'h006, 32'hA5A5A5A5, 4'hF, resp, pulse);
`ifdef AXIL_REG_BANK_ALIGN_CHECK_EN
        chk("t8_bresp", 64'(resp), 64'd2);
        chk("t8_pulse", 64'(pulse), 64'd0);
        chk("t8_reg1", 64'(rq(1)), 64'd0);
        axi_read(12'h007, rd, resp);
        chk("t8_rdata", 64'(rd), 64'd0);
        chk("t8_rresp", 64'(resp), 64'd2);
`else
        chk("t8_bresp", 64'(resp), 64'd0);
        chk("t8_pulse", 64'(pulse), 64'h0002);
        chk("t8_reg1", 64'(rq(1)), 64'hA5A5A5A5);
        axi_read(12'h007, rd, resp);
        chk("t8_rdata", 64'(rd), 64'hA5A5A5A5);
        chk("t8_rresp", 64'(resp), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
